// File: rtl/sensor_input_conditioner_if.sv
// Sensor bus between the board pins and the conditioner: raw pins in,
// committed vector plus derived water-level status out.
interface sensor_input_conditioner_if;
  logic [6:0] raw_sensors;
  logic [6:0] sensors;
  logic       sensors_update;
  logic [1:0] water_level_code;
  logic       sensor_fault;
  logic       settling;

  modport slave (
    input  raw_sensors,
    output sensors, sensors_update, water_level_code, sensor_fault, settling
  );

  modport master (
    output raw_sensors,
    input  sensors, sensors_update, water_level_code, sensor_fault, settling
  );
endinterface

// File: rtl/sensor_input_conditioner.sv
// Synchronises, debounces and atomically commits the seven field sensor lines.
// Define SENSOR_FAULT_LATCH_EN to make sensor_fault sticky until reset.
module sensor_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  sensor_input_conditioner_if.slave    bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_COMMIT} state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           r_state,     w_state;
  logic [6:0]       r_sync1,     r_sync2;
  logic [6:0]       r_candidate, w_candidate;
  logic [CNT_W-1:0] r_count,     w_count;
  logic [6:0]       r_sensors,   w_sensors;
  logic             r_update,    w_update;
  logic [1:0]       r_code,      w_code;
  logic             r_fault,     w_fault;
  logic             w_conflict;
  logic [1:0]       w_level;

  // L=bit0, M=bit1, H=bit2 of the pending vector
  assign w_conflict = (r_candidate[2] & ~r_candidate[1]) | (r_candidate[1] & ~r_candidate[0]);
  assign w_level    = r_candidate[2] ? 2'd3 :
                      r_candidate[1] ? 2'd2 :
                      r_candidate[0] ? 2'd1 : 2'd0;

  always_comb begin
    w_state     = r_state;
    w_candidate = r_candidate;
    w_count     = r_count;
    w_sensors   = r_sensors;
    w_update    = 1'b0;
    w_code      = r_code;
    w_fault     = r_fault;
    case (r_state)
      ST_IDLE: begin
        if (r_sync2 != r_sensors) begin
          w_candidate = r_sync2;
          w_count     = '0;
          w_state     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // Any deviation from the candidate, even back to the committed value, restarts qualification
        if (r_sync2 != r_candidate) begin
          w_candidate = r_sync2;
          w_count     = '0;
        end else begin
          if (r_count == LP_LAST) w_state = ST_COMMIT;
          if (r_count != '1)      w_count = r_count + CNT_W'(1);
        end
      end
      ST_COMMIT: begin
        w_state = ST_IDLE;
        if (r_candidate != r_sensors) begin
          w_sensors = r_candidate;
          w_update  = 1'b1;
          if (!w_conflict) w_code = w_level;
`ifdef SENSOR_FAULT_LATCH_EN
          w_fault = r_fault | w_conflict;
`else
          w_fault = w_conflict;
`endif
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_candidate <= '0;
      r_count     <= '0;
      r_sensors   <= '0;
      r_update    <= 1'b0;
      r_code      <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_sync1     <= bus.raw_sensors;
      r_sync2     <= r_sync1;
      r_candidate <= w_candidate;
      r_count     <= w_count;
      r_sensors   <= w_sensors;
      r_update    <= w_update;
      r_code      <= w_code;
      r_fault     <= w_fault;
    end
  end

  assign bus.sensors          = r_sensors;
  assign bus.sensors_update   = r_update;
  assign bus.water_level_code = r_code;
  assign bus.sensor_fault     = r_fault;
  assign bus.settling         = (r_state == ST_SETTLE);

endmodule
